// File: rtl/photo_reader_in.sv
// photo_reader_in
// Input side of the G-15 fast (photoelectric) tape path. Asynchronous 5-channel
// frames from the photo reader are synchronized and strobed by a sprocket-driven
// FSM (IDLE -> SETTLE -> CAPTURE -> WAITLOW). Forward frames go into a 2-deep
// FIFO that the input logic drains with a ready/take handshake. Reverse frames
// are not stored; they only flag a passing stop code.
//
// Ports:
//   CLOCK               system clock
//   rst                 asynchronous active-high reset
//   FAST_IN             fast input command active; its falling edge clears
//                       STOP_SEEN, OVERRUN, the FIFO and the FSM
//   PHOTO_READER_FWD    reader driving forward
//   PHOTO_READER_REV    reader driving reverse (wins if both are high)
//   PR_SPROCKET         sprocket-hole sensor, asynchronous
//   PR_DATA[4:0]        channel sensors, asynchronous, bit 4 = channel 5
//   IN_TAKE             input logic consumes IN_CODE this cycle
//   IN_CODE[4:0]        head-of-FIFO frame, 0 when empty
//   IN_READY            FIFO non-empty
//   PL6_PHOTO_TAPE_FWD  registered forward-drive request
//   STOP_SEEN           sticky, stop code read forward
//   REV_STOP            one-cycle pulse, stop code passed in reverse
//   OVERRUN             sticky, forward frame dropped on a full FIFO
//
// Configuration macro: G15_PR_OVERRUN_EN. When defined, OVERRUN tracks dropped
// frames; when undefined OVERRUN is tied low (frames are still dropped).

module photo_reader_in #(
    parameter int         SETTLE    = 4,
    parameter logic [4:0] STOP_CODE = 5'b10000
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       FAST_IN,
    input  logic       PHOTO_READER_FWD,
    input  logic       PHOTO_READER_REV,
    input  logic       PR_SPROCKET,
    input  logic [4:0] PR_DATA,
    input  logic       IN_TAKE,
    output logic [4:0] IN_CODE,
    output logic       IN_READY,
    output logic       PL6_PHOTO_TAPE_FWD,
    output logic       STOP_SEEN,
    output logic       REV_STOP,
    output logic       OVERRUN
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE, ST_WAITLOW} state_t;

    state_t     state;
    logic [3:0] settle_cnt;

    logic       spr_s1, spr_s2, spr_prev;
    logic [4:0] dat_s1, dat_s2;
    logic [1:0] sync_vld;
    logic       armed;
    logic       rise;
    logic       fast_d;

    logic [4:0] mem [2];
    logic       wr_ptr, rd_ptr;
    logic [1:0] count;

    logic fast_fall, capture, cap_fwd, cap_rev, is_stop;
    logic take, fifo_full, accept;

    // Two-flop synchronizers plus a registered rise detector. sync_vld marks
    // when spr_s2 holds a real sample after reset; armed then requires the
    // sprocket to be seen low, so a hole still lit across reset yields no frame.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, giving true pipeline behaviour.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            spr_s1   <= 1'b0;
            spr_s2   <= 1'b0;
            spr_prev <= 1'b0;
            dat_s1   <= '0;
            dat_s2   <= '0;
            sync_vld <= '0;
            armed    <= 1'b0;
            rise     <= 1'b0;
            fast_d   <= 1'b0;
        end else begin
            spr_s1   <= PR_SPROCKET;
            spr_s2   <= spr_s1;
            spr_prev <= spr_s2;
            dat_s1   <= PR_DATA;
            dat_s2   <= dat_s1;
            sync_vld <= {sync_vld[0], 1'b1};
            armed    <= armed | (sync_vld[1] & ~spr_s2);
            rise     <= spr_s2 & ~spr_prev & armed;
            fast_d   <= FAST_IN;
        end
    end

    assign fast_fall = fast_d & ~FAST_IN;
    assign capture   = (state == ST_CAPTURE);
    assign cap_rev   = capture & PHOTO_READER_REV;
    assign cap_fwd   = capture & ~PHOTO_READER_REV & PHOTO_READER_FWD;
    assign is_stop   = (dat_s2 == STOP_CODE);

    assign IN_READY  = (count != 2'd0);
    assign take      = IN_TAKE & IN_READY;
    assign fifo_full = (count == 2'd2);
    // A take in the same cycle frees the head slot, so a full FIFO still accepts.
    assign accept    = cap_fwd & ~fast_fall & (~fifo_full | take);
    assign IN_CODE   = IN_READY ? mem[rd_ptr] : 5'd0;

    // Frame FSM with its registered flags.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            STOP_SEEN  <= 1'b0;
            REV_STOP   <= 1'b0;
        end else begin
            REV_STOP <= cap_rev & is_stop & ~fast_fall;
            if (fast_fall) begin
                state     <= ST_IDLE;
                STOP_SEEN <= 1'b0;
            end else begin
                if (cap_fwd && is_stop)
                    STOP_SEEN <= 1'b1;
                case (state)
                    ST_IDLE: begin
                        if (rise && (PHOTO_READER_FWD || PHOTO_READER_REV)) begin
                            state      <= ST_SETTLE;
                            settle_cnt <= 4'(SETTLE - 1);
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == 4'd0)
                            state <= ST_CAPTURE;
                        else
                            settle_cnt <= settle_cnt - 4'd1;
                    end
                    ST_CAPTURE: state <= ST_WAITLOW;
                    ST_WAITLOW: begin
                        if (!spr_s2)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (fast_fall) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (accept)
                wr_ptr <= ~wr_ptr;
            if (take)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, accept} - {1'b0, take};
        end
    end

    // NOTE: FIFO storage is deliberately not reset; IN_CODE is forced to 0 while
    // the FIFO is empty, so stale entries are never visible.
    always_ff @(posedge CLOCK) begin
        if (accept)
            mem[wr_ptr] <= dat_s2;
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst)
            PL6_PHOTO_TAPE_FWD <= 1'b0;
        else
            PL6_PHOTO_TAPE_FWD <= FAST_IN & ~STOP_SEEN & ~fifo_full;
    end

`ifdef G15_PR_OVERRUN_EN
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst)
            OVERRUN <= 1'b0;
        else if (fast_fall)
            OVERRUN <= 1'b0;
        else if (cap_fwd && fifo_full && !take)
            OVERRUN <= 1'b1;
    end
`else
    assign OVERRUN = 1'b0;
`endif

endmodule

// File: tb/tb_photo_reader_in.sv
// Directed testbench for photo_reader_in (SETTLE=4, STOP_CODE=5'h10).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.

module tb_photo_reader_in;

    logic       CLOCK;
    logic       rst;
    logic       FAST_IN;
    logic       PHOTO_READER_FWD;
    logic       PHOTO_READER_REV;
    logic       PR_SPROCKET;
    logic [4:0] PR_DATA;
    logic       IN_TAKE;
    logic [4:0] IN_CODE;
    logic       IN_READY;
    logic       PL6_PHOTO_TAPE_FWD;
    logic       STOP_SEEN;
    logic       REV_STOP;
    logic       OVERRUN;

    int checks = 0;
    int errors = 0;

`ifdef G15_PR_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    photo_reader_in #(.SETTLE(4), .STOP_CODE(5'b10000)) dut (
        .CLOCK              (CLOCK),
        .rst                (rst),
        .FAST_IN            (FAST_IN),
        .PHOTO_READER_FWD   (PHOTO_READER_FWD),
        .PHOTO_READER_REV   (PHOTO_READER_REV),
        .PR_SPROCKET        (PR_SPROCKET),
        .PR_DATA            (PR_DATA),
        .IN_TAKE            (IN_TAKE),
        .IN_CODE            (IN_CODE),
        .IN_READY           (IN_READY),
        .PL6_PHOTO_TAPE_FWD (PL6_PHOTO_TAPE_FWD),
        .STOP_SEEN          (STOP_SEEN),
        .REV_STOP           (REV_STOP),
        .OVERRUN            (OVERRUN)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic start_frame(input logic [4:0] d);
        PR_DATA     = d;
        PR_SPROCKET = 1'b1;
    endtask

    task automatic end_frame();
        PR_SPROCKET = 1'b0;
        repeat (6) tick();
    endtask

    task automatic frame(input logic [4:0] d);
        start_frame(d);
        repeat (10) tick();
        end_frame();
    endtask

    task automatic take_one();
        IN_TAKE = 1'b1;
        tick();
        IN_TAKE = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        FAST_IN = 1'b0;
        PHOTO_READER_FWD = 1'b0;
        PHOTO_READER_REV = 1'b0;
        PR_SPROCKET = 1'b0;
        PR_DATA = 5'd0;
        IN_TAKE = 1'b0;
        repeat (3) tick();

        check("rst_in_code", 8'(IN_CODE), 8'h00);
        check("rst_in_ready", 8'(IN_READY), 8'h0);
        check("rst_pl6", 8'(PL6_PHOTO_TAPE_FWD), 8'h0);
        check("rst_stop_seen", 8'(STOP_SEEN), 8'h0);
        check("rst_rev_stop", 8'(REV_STOP), 8'h0);
        check("rst_overrun", 8'(OVERRUN), 8'h0);

        rst = 1'b0;
        FAST_IN = 1'b1;
        PHOTO_READER_FWD = 1'b1;
        repeat (5) tick();
        check("pl6_idle", 8'(PL6_PHOTO_TAPE_FWD), 8'h1);

        // Single frame: ready exactly 8 edges after the first edge seeing the sprocket.
        start_frame(5'h0B);
        repeat (8) tick();
        check("lat_not_yet", 8'(IN_READY), 8'h0);
        tick();
        check("lat_ready", 8'(IN_READY), 8'h1);
        check("lat_code", 8'(IN_CODE), 8'h0B);
        tick();
        end_frame();
        take_one();
        check("take_empty", 8'(IN_READY), 8'h0);
        check("take_code0", 8'(IN_CODE), 8'h00);

        // Three frames without takes: request drops after the second, third dropped.
        frame(5'h01);
        check("f1_pl6", 8'(PL6_PHOTO_TAPE_FWD), 8'h1);
        start_frame(5'h02);
        repeat (9) tick();
        check("f2_pl6_before", 8'(PL6_PHOTO_TAPE_FWD), 8'h1);
        tick();
        check("f2_pl6_drop", 8'(PL6_PHOTO_TAPE_FWD), 8'h0);
        end_frame();
        frame(5'h03);
        check("f3_overrun", 8'(OVERRUN), 8'(OVR_EXP));
        check("f3_head", 8'(IN_CODE), 8'h01);
        take_one();
        check("f3_second", 8'(IN_CODE), 8'h02);
        take_one();
        check("f3_empty", 8'(IN_READY), 8'h0);
        take_one();
        check("idle_take_ready", 8'(IN_READY), 8'h0);
        check("idle_take_code", 8'(IN_CODE), 8'h00);
        check("pl6_back", 8'(PL6_PHOTO_TAPE_FWD), 8'h1);

        // Forward stop code: delivered, flagged, request withdrawn; FAST_IN fall clears.
        frame(5'h10);
        check("stop_code", 8'(IN_CODE), 8'h10);
        check("stop_ready", 8'(IN_READY), 8'h1);
        check("stop_seen", 8'(STOP_SEEN), 8'h1);
        check("stop_pl6", 8'(PL6_PHOTO_TAPE_FWD), 8'h0);
        FAST_IN = 1'b0;
        tick();
        check("fall_stop", 8'(STOP_SEEN), 8'h0);
        check("fall_overrun", 8'(OVERRUN), 8'h0);
        check("fall_fifo", 8'(IN_READY), 8'h0);
        FAST_IN = 1'b1;
        repeat (2) tick();
        check("refast_pl6", 8'(PL6_PHOTO_TAPE_FWD), 8'h1);

        // Reverse: nothing stored, stop code gives a one-cycle pulse after CAPTURE.
        PHOTO_READER_FWD = 1'b0;
        PHOTO_READER_REV = 1'b1;
        frame(5'h05);
        check("rev_no_write", 8'(IN_READY), 8'h0);
        start_frame(5'h10);
        repeat (8) tick();
        check("rev_pulse_pre", 8'(REV_STOP), 8'h0);
        tick();
        check("rev_pulse", 8'(REV_STOP), 8'h1);
        tick();
        check("rev_pulse_post", 8'(REV_STOP), 8'h0);
        check("rev_stop_ready", 8'(IN_READY), 8'h0);
        check("rev_no_seen", 8'(STOP_SEEN), 8'h0);
        end_frame();
        PHOTO_READER_FWD = 1'b1;
        frame(5'h07);
        check("both_rev_wins", 8'(IN_READY), 8'h0);
        PHOTO_READER_REV = 1'b0;

        // Reset during SETTLE with the sprocket still lit: no frame until a fresh rise.
        start_frame(5'h0C);
        repeat (5) tick();
        rst = 1'b1;
        repeat (2) tick();
        check("midrst_ready", 8'(IN_READY), 8'h0);
        rst = 1'b0;
        repeat (15) tick();
        check("midrst_no_frame", 8'(IN_READY), 8'h0);
        end_frame();
        frame(5'h0C);
        check("midrst_new_ready", 8'(IN_READY), 8'h1);
        check("midrst_new_code", 8'(IN_CODE), 8'h0C);
        take_one();

        // Write and take in the same cycle with the FIFO full.
        frame(5'h11);
        frame(5'h12);
        start_frame(5'h13);
        repeat (8) tick();
        IN_TAKE = 1'b1;
        tick();
        IN_TAKE = 1'b0;
        check("simul_head", 8'(IN_CODE), 8'h12);
        check("simul_ready", 8'(IN_READY), 8'h1);
        check("simul_overrun", 8'(OVERRUN), 8'h0);
        tick();
        end_frame();
        check("simul_full_pl6", 8'(PL6_PHOTO_TAPE_FWD), 8'h0);
        take_one();
        check("simul_next", 8'(IN_CODE), 8'h13);
        take_one();
        check("simul_empty", 8'(IN_READY), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/photo_reader_in.md
# photo_reader_in

Input side of the G-15 fast (photoelectric) tape path. It receives asynchronous 5-channel frames from the photo reader and synchronizes and strobes them. It buffers frames in a 2-deep FIFO and hands them to the input logic with a ready/take handshake. It also generates the forward-drive request PL6_PHOTO_TAPE_FWD consumed by the I/O output decode, and flags stop codes in both tape directions.

## Interface
Parameters:
- SETTLE, 4: CLOCK cycles between the detected sprocket rise and the data sample (range 1–15).
- STOP_CODE, 5'b10000: frame value treated as the tape stop code.

Ports:
- CLOCK  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- FAST_IN  in  1  fast input command active
- PHOTO_READER_FWD  in  1  reader driving forward (permit-qualified)
- PHOTO_READER_REV  in  1  reader driving reverse (permit-qualified)
- PR_SPROCKET  in  1  sprocket-hole sensor; asynchronous
- PR_DATA  in  5  channel sensors; asynchronous; bit 4 is channel 5
- IN_TAKE  in  1  input logic consumes IN_CODE this cycle
- IN_CODE  out  5  head-of-FIFO frame
- IN_READY  out  1  FIFO non-empty
- PL6_PHOTO_TAPE_FWD  out  1  forward-drive request
- STOP_SEEN  out  1  sticky; stop code read forward
- REV_STOP  out  1  one-cycle pulse; stop code passed in reverse
- OVERRUN  out  1  sticky overrun flag (see Configuration)

## Operation
- Synchronization: PR_SPROCKET and PR_DATA each pass through 2 flops. A rise is detected from the synchronized sprocket and its previous value.
- FSM states are IDLE, SETTLE, CAPTURE, WAITLOW.
  - IDLE → SETTLE on a detected rise while PHOTO_READER_FWD or PHOTO_READER_REV is high. Rises with neither high are ignored.
  - SETTLE loads a 4-bit counter with SETTLE−1 and decrements it. At 0 it goes to CAPTURE.
  - CAPTURE samples the synchronized PR_DATA for one cycle, then goes to WAITLOW.
  - WAITLOW → IDLE when the synchronized sprocket is low.
- CAPTURE in forward direction (PHOTO_READER_FWD=1):
  - The frame is written to the FIFO.
  - If frame == STOP_CODE, STOP_SEEN sets. The stop code is still delivered.
  - If the FIFO is full, the frame is dropped and OVERRUN sets (when enabled).
- CAPTURE in reverse direction (PHOTO_READER_REV=1):
  - Nothing is written to the FIFO.
  - If frame == STOP_CODE, REV_STOP pulses 1 cycle.
  - If both direction inputs are high, reverse wins.
- FIFO: 2 entries, 1-bit write and read pointers plus a count of 0..2.
  - IN_CODE shows the head entry and is 0 when empty.
  - IN_TAKE with IN_READY=0 is ignored.
  - A write and a take in the same cycle with count=2 pops the head and accepts the write; no overrun.
- PL6_PHOTO_TAPE_FWD = FAST_IN & ~STOP_SEEN & (count < 2), registered.
- A falling edge of FAST_IN clears STOP_SEEN, OVERRUN and the FIFO, and returns the FSM to IDLE.
- rst mid-frame: everything returns to reset values immediately. A sprocket still high after release produces no frame until it goes low and rises again.

## Timing
- Reset values:
  - IN_CODE=0, IN_READY=0, PL6_PHOTO_TAPE_FWD=0, STOP_SEEN=0, REV_STOP=0, OVERRUN=0.
  - FSM in IDLE, FIFO count 0, synchronizers 0.
- Latency: PR_SPROCKET high at CLOCK edge N (setup met) → edge detect true after edge N+2.
  - SETTLE phase spans SETTLE cycles, followed by one CAPTURE cycle.
  - IN_READY and IN_CODE valid after edge N+SETTLE+4; with SETTLE=4, at N+8.
- PR_DATA must be stable from edge N+SETTLE+1 through N+SETTLE+3.
- IN_TAKE is sampled at the CLOCK edge. IN_READY/IN_CODE update after that same edge.
- PL6_PHOTO_TAPE_FWD drops one cycle after the count reaches 2 or STOP_SEEN sets.
- REV_STOP is high for exactly the cycle after CAPTURE.
- Minimum sprocket period handled: SETTLE+6 cycles.

## Configuration
- G15_PR_OVERRUN_EN defined: OVERRUN sets when a forward frame is dropped on a full FIFO. It stays set until rst or a FAST_IN fall.
- G15_PR_OVERRUN_EN undefined: OVERRUN is tied 0 and no tracking logic is built. Dropping behaviour is unchanged.

## Test plan
- Reset, then FAST_IN=1, FWD=1, one sprocket with PR_DATA=5'h0B, SETTLE=4 → IN_READY=1 and IN_CODE=0x0B 8 cycles after the rise; IN_TAKE → IN_READY=0 next cycle.
- Three forward frames 0x01,0x02,0x03 with no IN_TAKE:
  - FWD request drops after the second frame.
  - Third frame dropped, OVERRUN=1 (macro on) / 0 (macro off).
  - Takes return 0x01 then 0x02.
- Forward frame 5'h10 → delivered as 0x10, STOP_SEEN=1, PL6_PHOTO_TAPE_FWD=0. Drop FAST_IN → STOP_SEEN=0.
- REV=1, frames 0x05, 0x10 → IN_READY stays 0, REV_STOP one-cycle pulse after the second frame's CAPTURE.
- rst asserted during SETTLE with sprocket held high, released → no frame until the sprocket falls and rises again.
- Simultaneous CAPTURE write and IN_TAKE at count=2 → count stays 2, OVERRUN=0, order preserved.
